// File: rtl/mips_pkg.sv
// mips_pkg: instruction classes, field positions and width defaults shared by the MIPS32 pipeline stages
package mips_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int NREG_DEF = 2**AW_DEF;
  localparam logic [2:0] CLS_RR = 3'd0;
  localparam logic [2:0] CLS_RI = 3'd1;
  localparam logic [2:0] CLS_LD = 3'd2;
  localparam logic [2:0] CLS_ST = 3'd3;
  localparam logic [2:0] CLS_BR = 3'd4;
  localparam logic [2:0] CLS_HALT = 3'd5;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  function automatic logic class_writes(input logic [2:0] cls);
    return cls == CLS_RR || cls == CLS_RI || cls == CLS_LD;
  endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREG x DW register file, one synchronous write port, two asynchronous read ports, R0 reads 0
// Ports: clk; rst (async active-low clear); we/wa/wd write port; ra_a/ra_b read indices; rd_a/rd_b read data.
// WB_BYPASS_EN: when defined, a same-cycle write to a read index is forwarded to that read port (never for R0).
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NREG = 2**AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra_a,
  input  logic [AW-1:0] ra_b,
  output logic [DW-1:0] rd_a,
  output logic [DW-1:0] rd_b
);
  logic [DW-1:0] mem [NREG];
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we && wa != '0) mem[wa] <= wd;
`ifdef WB_BYPASS_EN
  always_comb begin
    rd_a = ra_a == '0 ? '0 : (we && wa == ra_a) ? wd : mem[ra_a];
    rd_b = ra_b == '0 ? '0 : (we && wa == ra_b) ? wd : mem[ra_b];
  end
`else
  always_comb begin
    rd_a = ra_a == '0 ? '0 : mem[ra_a];
    rd_b = ra_b == '0 ? '0 : mem[ra_b];
  end
`endif
endmodule

// File: rtl/writeback_regfile_stage.sv
// writeback_regfile_stage: MIPS32 WB stage committing MEM/WB results to the register file, with sticky halt and write counter
// Ports: clk; rst (async active-low); type45/INS45/ALUout45/TLD45 from MEM/WB; rs_addr/rt_addr -> rs_data/rt_data
//        decode read ports; halt_f sticky halt to upstream stages; wb_count committed-write count.
// WB_BYPASS_EN: when defined, the register file forwards the committing value to same-cycle reads.
module writeback_regfile_stage
  import mips_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    type45,
  input  logic [31:0]   INS45,
  input  logic [DW-1:0] ALUout45,
  input  logic [DW-1:0] TLD45,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          halt_f,
  output logic [31:0]   wb_count
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_n;
  logic [AW-1:0] rd;
  logic [DW-1:0] wdata;
  logic we;
  logic unused_ins;
  assign unused_ins = ^{INS45[31:RT_HI+1], INS45[RD_LO-1:0]};
  always_comb begin
    rd = type45 == CLS_RR ? INS45[RD_HI:RD_LO] : INS45[RT_HI:RT_LO];
    wdata = type45 == CLS_LD ? TLD45 : ALUout45;
    we = class_writes(type45) && rd != '0 && !halt_f;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else state <= state_n;
  always_comb begin
    state_n = state == RUN && type45 == CLS_HALT ? HALTED : state;
    halt_f = state == HALTED;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) wb_count <= '0;
    else if (we) wb_count <= wb_count + 32'd1;
  regfile_2r1w #(.DW(DW), .AW(AW), .NREG(NREG)) u_rf (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wa(rd),
    .wd(wdata),
    .ra_a(rs_addr),
    .ra_b(rt_addr),
    .rd_a(rs_data),
    .rd_b(rt_data)
  );
endmodule

// File: tb/tb_writeback_regfile_stage.sv
// tb_writeback_regfile_stage: directed vector table, halt/reset sequences and randomized traffic against a register-array model
module tb_writeback_regfile_stage;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] type45 = '0;
  logic [31:0] ins45 = '0, alu45 = '0, tld45 = '0;
  logic [4:0] rs_addr = '0, rt_addr = '0;
  logic [31:0] rs_data, rt_data, wb_count;
  logic halt_f;
  always #5 clk = ~clk;
  writeback_regfile_stage dut (
    .clk(clk), .rst(rst), .type45(type45), .INS45(ins45), .ALUout45(alu45), .TLD45(tld45),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .halt_f(halt_f), .wb_count(wb_count)
  );
  logic [31:0] model [32];
  bit m_halt;
  logic [31:0] m_cnt;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic [2:0] t;
    logic [31:0] ins, alu, tld;
    logic [4:0] rs, rt;
    logic [31:0] e_rs, e_rt;
    logic e_halt;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t tbl [9];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic void m_dest(output bit w, output int r, output logic [31:0] d);
    w = type45 <= 3'd2 && !m_halt;
    r = type45 == 3'd0 ? int'(ins45[15:11]) : int'(ins45[20:16]);
    d = type45 == 3'd2 ? tld45 : alu45;
    if (r == 0) w = 0;
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    bit w;
    int r;
    logic [31:0] d;
    m_dest(w, r, d);
    if (a == 0) return 0;
    if (BYP && w && r == int'(a)) return d;
    return model[a];
  endfunction
  task automatic m_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
    m_halt = 0;
    m_cnt = '0;
  endtask
  task automatic drive(input logic [2:0] t, input logic [31:0] ins, input logic [31:0] alu,
                       input logic [31:0] tld, input logic [4:0] rs, input logic [4:0] rt);
    type45 = t;
    ins45 = ins;
    alu45 = alu;
    tld45 = tld;
    rs_addr = rs;
    rt_addr = rt;
    #4;
  endtask
  task automatic advance();
    bit w;
    int r;
    logic [31:0] d;
    m_dest(w, r, d);
    @(posedge clk);
    if (w) begin
      model[r] = d;
      m_cnt++;
    end
    if (type45 == 3'd5) m_halt = 1;
    #1;
  endtask
  task automatic model_check(input string tag);
    check({tag, "_rs"}, rs_data, m_read(rs_addr));
    check({tag, "_rt"}, rt_data, m_read(rt_addr));
    check({tag, "_halt"}, {31'd0, halt_f}, {31'd0, m_halt});
    check({tag, "_cnt"}, wb_count, m_cnt);
  endtask
  task automatic do_reset(input bit full);
    #1 rst = 1'b0;
    #1;
    m_clear();
    check("rst_halt", {31'd0, halt_f}, 32'd0);
    check("rst_cnt", wb_count, 32'd0);
    if (full)
      for (int i = 0; i < 32; i++) begin
        rs_addr = 5'(i);
        rt_addr = 5'(31 - i);
        #1;
        check("rst_rs", rs_data, 32'd0);
        check("rst_rt", rt_data, 32'd0);
      end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask
  initial begin
    int halted_cycles;
    m_clear();
    tbl[0] = '{3'd0, 32'h0029_2800, 32'h0000_00A5, 32'h77, 5'd5, 5'd9, BYP ? 32'hA5 : 32'h0, 32'h0, 1'b0, 32'd0};
    tbl[1] = '{3'd2, 32'h0009_1800, 32'h0000_1234, 32'hDEAD_BEEF, 5'd5, 5'd9, 32'hA5, BYP ? 32'hDEAD_BEEF : 32'h0, 1'b0, 32'd1};
    tbl[2] = '{3'd1, 32'h0000_2000, 32'hFFFF_FFFF, 32'h0, 5'd9, 5'd3, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'd2};
    tbl[3] = '{3'd3, 32'h0009_2800, 32'h0000_0BAD, 32'hBAD, 5'd0, 5'd4, 32'h0, 32'h0, 1'b0, 32'd2};
    tbl[4] = '{3'd1, 32'h0007_2800, 32'h0000_0011, 32'h0, 5'd5, 5'd0, 32'hA5, 32'h0, 1'b0, 32'd2};
    tbl[5] = '{3'd0, 32'h0000_3800, 32'h0000_0055, 32'h0, 5'd7, 5'd7, BYP ? 32'h55 : 32'h11, BYP ? 32'h55 : 32'h11, 1'b0, 32'd3};
    tbl[6] = '{3'd4, 32'h0007_3800, 32'h0000_0099, 32'h0, 5'd7, 5'd9, 32'h55, 32'hDEAD_BEEF, 1'b0, 32'd4};
    tbl[7] = '{3'd6, 32'h0005_2800, 32'h0000_0066, 32'h0, 5'd5, 5'd7, 32'hA5, 32'h55, 1'b0, 32'd4};
    tbl[8] = '{3'd7, 32'h0005_2800, 32'h0000_0067, 32'h0, 5'd5, 5'd7, 32'hA5, 32'h55, 1'b0, 32'd4};
    repeat (2) @(posedge clk);
    #1;
    check("init_halt", {31'd0, halt_f}, 32'd0);
    check("init_cnt", wb_count, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].t, tbl[i].ins, tbl[i].alu, tbl[i].tld, tbl[i].rs, tbl[i].rt);
      check("tbl_rs", rs_data, tbl[i].e_rs);
      check("tbl_rt", rt_data, tbl[i].e_rt);
      check("tbl_halt", {31'd0, halt_f}, {31'd0, tbl[i].e_halt});
      check("tbl_cnt", wb_count, tbl[i].e_cnt);
      advance();
    end
    drive(3'd5, 32'h0000_1800, 32'h0000_0033, 32'h0, 5'd3, 5'd7);
    check("halt_pre", {31'd0, halt_f}, 32'd0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, 32'h0000_1800, 32'h0000_0033, 32'h0, 5'd3, 5'd7);
      check("halt_set", {31'd0, halt_f}, 32'd1);
      check("halt_r3", rs_data, 32'h0);
      check("halt_r7", rt_data, 32'h55);
      check("halt_cnt", wb_count, 32'd4);
      advance();
    end
    do_reset(1'b1);
    halted_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      logic [2:0] t;
      logic [31:0] ins;
      t = 3'($urandom_range(0, 7));
      if (t == 3'd5 && $urandom_range(0, 19) != 0) t = 3'd0;
      ins = $urandom;
      drive(t, ins, $urandom, $urandom,
            $urandom_range(0, 1) ? ins[15:11] : 5'($urandom),
            $urandom_range(0, 1) ? ins[20:16] : 5'($urandom));
      model_check("rand");
      advance();
      if (m_halt && ++halted_cycles > 4) begin
        halted_cycles = 0;
        do_reset(1'b0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
